// File: rtl/txll_pkg.sv
// Shared definitions for the SATA transmit link FIFO: frame-word layout and field positions.
package txll_pkg;

    localparam int TXLL_WORD_W  = 36;
    localparam int TXLL_EOF_BIT = 34;
    localparam int TXLL_SOF_BIT = 35;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [1:0]  pt;
        logic [31:0] data;
    } txll_word_t;

endpackage

// File: rtl/txll_dpram.sv
// Simple dual-port RAM, single clock, one write port and one registered read port.
module txll_dpram
    import txll_pkg::*;
#(
    parameter int C_DEPTH  = 512,
    parameter int C_ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [C_ADDR_W-1:0]    wr_addr,
    input  logic [TXLL_WORD_W-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [C_ADDR_W-1:0]    rd_addr,
    output logic [TXLL_WORD_W-1:0] rd_data
);

    logic [TXLL_WORD_W-1:0] mem [C_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the FIFO output register, so it clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/txll_fifo.sv
// Store-and-forward SATA transmit link FIFO with first-word-fall-through read side.
// Optional uncommitted-frame discard is enabled by defining TXLL_ABORT_EN.
module txll_fifo
    import txll_pkg::*;
#(
    parameter int C_DEPTH       = 512,
    parameter int C_PTR_WIDTH   = 9,
    parameter int C_ALMOST_FULL = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TXLL_WORD_W-1:0] wr_di,
    input  logic                   wr_en,
    input  logic                   wr_abort,
    output logic                   wr_full,
    output logic                   wr_almost_full,
    output logic [9:0]             wr_count,
    output logic                   wr_err,
    output logic [TXLL_WORD_W-1:0] rd_do,
    output logic                   rd_valid,
    input  logic                   rd_en,
    output logic [7:0]             rd_frame_cnt,
    output logic                   rd_eof_rdy
);

    localparam int PW = C_PTR_WIDTH;
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] DEPTH_V = C_DEPTH[PW:0];
    localparam logic [PW:0] AFULL_V = C_ALMOST_FULL[PW:0];

    logic [PW:0] wr_ptr;
    logic [PW:0] cm_ptr;
    logic [PW:0] rd_ptr;
    logic [PW:0] occ;
    txll_word_t  wr_word;
    logic        discard;
    logic        wr_accept;
    logic        wr_store;
    logic        wr_commit;
    logic        pop;
    logic        pop_eof;
    logic        load;

`ifdef TXLL_ABORT_EN
    assign discard = wr_abort;
`else
    logic unused_abort;
    assign unused_abort = wr_abort;
    assign discard      = 1'b0;
`endif

    assign wr_word   = wr_di;
    assign wr_accept = wr_en && !wr_full;
    assign wr_store  = wr_accept && !discard;
    assign wr_commit = wr_store && wr_word.eof;
    assign pop       = rd_en && rd_valid;
    assign pop_eof   = pop && rd_do[TXLL_EOF_BIT];
    // Only words behind the commit pointer may move into the output register.
    assign load      = (!rd_valid || pop) && (rd_ptr != cm_ptr);

    assign occ            = wr_ptr - rd_ptr + {{PW{1'b0}}, rd_valid};
    assign wr_full        = (occ == DEPTH_V);
    assign wr_almost_full = (occ >= AFULL_V);
    assign wr_count       = 10'(occ);
    assign rd_eof_rdy     = (rd_frame_cnt != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && wr_full;
            if (discard) begin
                wr_ptr <= cm_ptr;
            end else if (wr_store) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_commit) begin
                cm_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else if (load) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            rd_valid <= 1'b1;
        end else if (pop) begin
            rd_valid <= 1'b0;
        end
    end

    // A commit and an eof pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_frame_cnt <= 8'd0;
        end else begin
            case ({wr_commit, pop_eof})
                2'b10: if (rd_frame_cnt != 8'hFF) rd_frame_cnt <= rd_frame_cnt + 8'd1;
                2'b01: if (rd_frame_cnt != 8'h00) rd_frame_cnt <= rd_frame_cnt - 8'd1;
                default: rd_frame_cnt <= rd_frame_cnt;
            endcase
        end
    end

    txll_dpram #(
        .C_DEPTH  (C_DEPTH),
        .C_ADDR_W (PW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_store),
        .wr_addr (wr_ptr[PW-1:0]),
        .wr_data (wr_word),
        .rd_en   (load),
        .rd_addr (rd_ptr[PW-1:0]),
        .rd_data (rd_do)
    );

endmodule

// File: tb/tb_txll_fifo.sv
// Directed self-checking bench for txll_fifo; abort scenario runs only with TXLL_ABORT_EN.
module tb_txll_fifo;
    import txll_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] wr_di = '0;
    logic        wr_en = 1'b0;
    logic        wr_abort = 1'b0;
    logic        wr_full;
    logic        wr_almost_full;
    logic [9:0]  wr_count;
    logic        wr_err;
    logic [35:0] rd_do;
    logic        rd_valid;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_frame_cnt;
    logic        rd_eof_rdy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    txll_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .wr_di          (wr_di),
        .wr_en          (wr_en),
        .wr_abort       (wr_abort),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_count       (wr_count),
        .wr_err         (wr_err),
        .rd_do          (rd_do),
        .rd_valid       (rd_valid),
        .rd_en          (rd_en),
        .rd_frame_cnt   (rd_frame_cnt),
        .rd_eof_rdy     (rd_eof_rdy)
    );

    function automatic logic [35:0] mkWord(input int idx, input int len, input int base, input bit eofLast);
        logic [31:0] d;
        logic [1:0]  pt;
        d  = 32'(base + idx);
        pt = 2'(idx);
        return {idx == 0, eofLast && (idx == len - 1), pt, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [35:0] di, input logic re, input logic ab);
        wr_en    = we;
        wr_di    = di;
        rd_en    = re;
        wr_abort = ab;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " rd_valid"},       36'(rd_valid),       36'd0);
        checkOutput({tag, " rd_do"},          rd_do,               36'd0);
        checkOutput({tag, " rd_frame_cnt"},   36'(rd_frame_cnt),   36'd0);
        checkOutput({tag, " rd_eof_rdy"},     36'(rd_eof_rdy),     36'd0);
        checkOutput({tag, " wr_full"},        36'(wr_full),        36'd0);
        checkOutput({tag, " wr_almost_full"}, 36'(wr_almost_full), 36'd0);
        checkOutput({tag, " wr_count"},       36'(wr_count),       36'd0);
        checkOutput({tag, " wr_err"},         36'(wr_err),         36'd0);
    endtask

    task automatic writeFrame(input int len, input int base, input bit eofLast);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, mkWord(i, len, base, eofLast), 1'b0, 1'b0);
        end
        wr_en = 1'b0;
    endtask

    task automatic popFrame(input int len, input int base, input string tag);
        for (int i = 0; i < len; i++) begin
            checkOutput({tag, " rd_valid"}, 36'(rd_valid), 36'd1);
            checkOutput({tag, " rd_do"}, rd_do, mkWord(i, len, base, 1'b1));
            applyStimulus(1'b0, 36'd0, 1'b1, 1'b0);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and idle behaviour
        rst = 1'b1;
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkReset("reset");
        rst = 1'b0;
        applyStimulus(1'b0, 36'd0, 1'b1, 1'b0);
        checkOutput("empty pop rd_valid", 36'(rd_valid), 36'd0);
        checkOutput("empty pop wr_count", 36'(wr_count), 36'd0);
        rd_en = 1'b0;

        // Four-word frame becomes visible only after its EOF
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, mkWord(i, 4, 100, 1'b1), 1'b0, 1'b0);
            checkOutput("frame4 hold rd_valid", 36'(rd_valid), 36'd0);
        end
        checkOutput("frame4 frame_cnt", 36'(rd_frame_cnt), 36'd1);
        checkOutput("frame4 wr_count", 36'(wr_count), 36'd4);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("frame4 eof_rdy", 36'(rd_eof_rdy), 36'd1);
        popFrame(4, 100, "frame4");
        checkOutput("frame4 done rd_valid", 36'(rd_valid), 36'd0);
        checkOutput("frame4 done frame_cnt", 36'(rd_frame_cnt), 36'd0);
        checkOutput("frame4 done wr_count", 36'(wr_count), 36'd0);

        // Fill with uncommitted words up to full, then overflow
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b1, mkWord(i, 512, 5000, 1'b0), 1'b0, 1'b0);
            if (i == 254) begin
                checkOutput("fill 255 almost_full", 36'(wr_almost_full), 36'd0);
            end
            if (i == 255) begin
                checkOutput("fill 256 almost_full", 36'(wr_almost_full), 36'd1);
                checkOutput("fill 256 wr_count", 36'(wr_count), 36'd256);
            end
        end
        checkOutput("fill wr_full", 36'(wr_full), 36'd1);
        checkOutput("fill wr_count", 36'(wr_count), 36'd512);
        checkOutput("fill wr_err", 36'(wr_err), 36'd0);
        checkOutput("fill rd_valid", 36'(rd_valid), 36'd0);
        applyStimulus(1'b1, mkWord(0, 1, 9999, 1'b1), 1'b0, 1'b0);
        checkOutput("overflow wr_err", 36'(wr_err), 36'd1);
        checkOutput("overflow wr_count", 36'(wr_count), 36'd512);
        checkOutput("overflow frame_cnt", 36'(rd_frame_cnt), 36'd0);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("overflow wr_err pulse", 36'(wr_err), 36'd0);
        checkOutput("overflow rd_valid", 36'(rd_valid), 36'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Three one-word frames, then continuous pops
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkWord(0, 1, 200 + i, 1'b1), 1'b0, 1'b0);
            checkOutput("short frame_cnt up", 36'(rd_frame_cnt), 36'(i + 1));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("short rd_valid", 36'(rd_valid), 36'd1);
            checkOutput("short rd_do", rd_do, mkWord(0, 1, 200 + i, 1'b1));
            checkOutput("short frame_cnt down", 36'(rd_frame_cnt), 36'(3 - i));
            applyStimulus(1'b0, 36'd0, 1'b1, 1'b0);
        end
        rd_en = 1'b0;
        checkOutput("short end rd_valid", 36'(rd_valid), 36'd0);
        checkOutput("short end frame_cnt", 36'(rd_frame_cnt), 36'd0);

        // EOF write and EOF pop in the same cycle
        applyStimulus(1'b1, mkWord(0, 1, 300, 1'b1), 1'b0, 1'b0);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("overlap pre frame_cnt", 36'(rd_frame_cnt), 36'd1);
        applyStimulus(1'b1, mkWord(0, 1, 301, 1'b1), 1'b1, 1'b0);
        checkOutput("overlap frame_cnt", 36'(rd_frame_cnt), 36'd1);
        checkOutput("overlap rd_valid", 36'(rd_valid), 36'd0);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("overlap second rd_do", rd_do, mkWord(0, 1, 301, 1'b1));
        applyStimulus(1'b0, 36'd0, 1'b1, 1'b0);
        rd_en = 1'b0;
        checkOutput("overlap end frame_cnt", 36'(rd_frame_cnt), 36'd0);

        // Pointer wrap: 300-word frame drained, then a 400-word frame
        writeFrame(300, 1000, 1'b1);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        popFrame(300, 1000, "wrap300");
        checkOutput("wrap300 wr_count", 36'(wr_count), 36'd0);
        writeFrame(400, 2000, 1'b1);
        checkOutput("wrap400 peak wr_count", 36'(wr_count), 36'd400);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("wrap400 held wr_count", 36'(wr_count), 36'd400);
        popFrame(400, 2000, "wrap400");
        checkOutput("wrap400 end rd_valid", 36'(rd_valid), 36'd0);
        checkOutput("wrap400 end wr_count", 36'(wr_count), 36'd0);

`ifdef TXLL_ABORT_EN
        // Abort drops uncommitted words and a same-cycle EOF write
        writeFrame(2, 400, 1'b1);
        writeFrame(5, 500, 1'b0);
        checkOutput("abort pre wr_count", 36'(wr_count), 36'd7);
        applyStimulus(1'b1, mkWord(0, 1, 600, 1'b1), 1'b0, 1'b1);
        wr_abort = 1'b0;
        wr_en    = 1'b0;
        checkOutput("abort wr_count", 36'(wr_count), 36'd2);
        checkOutput("abort frame_cnt", 36'(rd_frame_cnt), 36'd1);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        popFrame(2, 400, "abort");
        checkOutput("abort end rd_valid", 36'(rd_valid), 36'd0);
        checkOutput("abort end wr_count", 36'(wr_count), 36'd0);
        checkOutput("abort end frame_cnt", 36'(rd_frame_cnt), 36'd0);
`endif

        // Reset in the middle of popping a committed frame
        writeFrame(3, 700, 1'b1);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("midreset head", rd_do, mkWord(0, 3, 700, 1'b1));
        applyStimulus(1'b0, 36'd0, 1'b1, 1'b0);
        checkOutput("midreset second", rd_do, mkWord(1, 3, 700, 1'b1));
        rst = 1'b1;
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkReset("midreset");
        rst = 1'b0;
        writeFrame(2, 800, 1'b1);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        popFrame(2, 800, "postreset");
        checkOutput("postreset rd_valid", 36'(rd_valid), 36'd0);
        checkOutput("postreset frame_cnt", 36'(rd_frame_cnt), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/txll_fifo.md
# txll_fifo

Single-clock store-and-forward transmit buffer for the SATA link layer, the transmit-side counterpart of the receive link FIFO. The transport layer writes 36-bit frame words. The link layer may read a frame only after that frame's EOF word has been written. Frames never start on the wire and then underrun. The read side is first-word-fall-through.

## Interface
Parameters:
- C_DEPTH, 512, word capacity; must be a power of two.
- C_PTR_WIDTH, 9, log2(C_DEPTH).
- C_ALMOST_FULL, 256, occupancy at or above which wr_almost_full asserts.

Ports:
- clk  in  1  the single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_di  in  36  [31:0] data, [33:32] pass-through, [34] EOF, [35] SOF.
- wr_en  in  1  write strobe.
- wr_abort  in  1  discards the uncommitted frame; ignored unless TXLL_ABORT_EN is defined.
- wr_full  out  1  occupancy == C_DEPTH.
- wr_almost_full  out  1  occupancy >= C_ALMOST_FULL.
- wr_count  out  10  occupancy, 0..C_DEPTH; upper bits are zero when the pointer is narrower.
- wr_err  out  1  one-cycle pulse when a write is dropped.
- rd_do  out  36  head word.
- rd_valid  out  1  rd_do holds a committed word.
- rd_en  in  1  pop; takes effect only when rd_valid is high.
- rd_frame_cnt  out  8  committed frames not yet fully popped; saturates at 255.
- rd_eof_rdy  out  1  rd_frame_cnt != 0.

## Operation
- Storage is a circular RAM. Pointers wr_ptr, cm_ptr (commit) and rd_ptr are each C_PTR_WIDTH+1 bits; the MSB is the wrap bit.
- Write is accepted iff wr_en && !wr_full. An accepted write stores at wr_ptr and increments wr_ptr.
- A write attempted while wr_full is dropped and pulses wr_err on the next cycle.
- Commit: an accepted write with wr_di[34]=1 sets cm_ptr to wr_ptr+1 and increments rd_frame_cnt.
- Prefetch: while the output register is empty or being popped, and rd_ptr != cm_ptr, the RAM word at rd_ptr loads into the output register and rd_ptr increments.
- Only committed words are ever prefetched.
- Pop: rd_en && rd_valid consumes the head. A popped word with [34]=1 decrements rd_frame_cnt.
- An rd_en without rd_valid is ignored.
- Occupancy = wr_ptr - rd_ptr + (output register full). It includes uncommitted words.
- Simultaneous eof-write and eof-pop leave rd_frame_cnt unchanged.
- A write at full with a same-cycle pop is still dropped, because full is evaluated before the pop.
- SOF is not checked. Words are stored and forwarded unchanged.
- Reset mid-frame discards all contents, including a partially popped frame.

## Timing
- Reset values: rd_valid=0, rd_do=0, rd_frame_cnt=0, rd_eof_rdy=0, wr_full=0, wr_almost_full=0, wr_count=0, wr_err=0. All pointers are 0.
- Into an empty buffer, an EOF word accepted at edge E gives rd_valid=1 after edge E+1. rd_do is valid in the same cycle.
- With back-to-back pops, rd_valid stays high and the words are gap-free until cm_ptr is reached.
- wr_count, wr_full and wr_almost_full update on the edge following the write or pop.
- rd_frame_cnt updates on the edge of the commit or the eof pop.

## Configuration
- TXLL_ABORT_EN defined:
  - wr_abort high at an edge sets wr_ptr to cm_ptr, discarding all uncommitted words.
  - A write in the same cycle is discarded.
  - An eof-write in the same cycle is not committed.
  - Occupancy drops accordingly on the next cycle.
  - Committed frames are unaffected.
- TXLL_ABORT_EN undefined: wr_abort is unused and has no effect. All other behaviour is identical.

## Structure
- Package txll_pkg:
  - TXLL_WORD_W=36.
  - TXLL_EOF_BIT=34.
  - TXLL_SOF_BIT=35.
  - The frame-word field typedef.
- Sub-module txll_dpram: a simple dual-port RAM.
  - One write port and one read port.
  - Registered read, single clock.
  - Sized by C_DEPTH and TXLL_WORD_W.

## Test plan
- Write 4 words, SOF on the first and EOF on the fourth. Require rd_valid=0 through the third write; rd_valid=1 one edge after the EOF write; rd_frame_cnt=1; 4 words popped in order; then rd_frame_cnt=0.
- Fill 512 words with no EOF. Require wr_full=1 and wr_count=512. A 513th write gives a wr_err pulse and is lost; rd_valid stays 0.
- Write three 1-word frames back to back, then pop continuously. Require rd_frame_cnt 3→0 and rd_valid gap-free for 3 cycles.
- Pointer wrap: 300 words popped, then a 400-word frame. Require correct order across the wrap and wr_count peaking at 400.
- With TXLL_ABORT_EN: one committed 2-word frame, plus 5 uncommitted words, then wr_abort. Require wr_count 7→2; only the 2 committed words are read out.
- Reset asserted mid-pop of a committed frame. Require all outputs at reset values the next cycle; the next frame after reset is read out intact.
